wic_ctrl: RTL

WIC_CTRL -- requirements
Module: wic_ctrl

---
 rtl/wic_pkg.sv | 23 ++
 rtl/wic_int_src.sv | 51 +++++
 rtl/wic_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/wic_pkg.sv
// wic_pkg: shared definitions for the wake-up interrupt controller.
//   wic_state_e    - wake handshake FSM states (IDLE=0, ARMED=1, REQ=2, DROP=3)
//   WIC_CFG_LEVEL  - ctl_xx_int_cfg encoding for a level-mode source
//   WIC_CFG_EDGE   - ctl_xx_int_cfg encoding for a rising-edge source
//   wic_id_width() - source-ID width for a given source count, max(1, clog2(n))
package wic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    REQ   = 2'd2,
    DROP  = 2'd3
  } wic_state_e;

  localparam logic WIC_CFG_LEVEL = 1'b0;
  localparam logic WIC_CFG_EDGE  = 1'b1;

  // A single source still needs a 1-bit ID port.
  function automatic int wic_id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wic_int_src.sv
// wic_int_src: one interrupt source of the WIC.
//   Synchronises the raw line, detects rising edges and keeps the pending bit.
// Ports:
//   wic_clk      in   clock, all state on rising edge
//   pad_cpu_rst  in   synchronous active-high reset
//   raw_int      in   raw asynchronous interrupt line
//   int_cfg      in   mode: 0 = level, 1 = rising edge
//   ack_clr      in   one-cycle clear pulse from the acknowledge decoder
//   pending      out  registered pending bit
module wic_int_src
  import wic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic wic_clk,
  input  logic pad_cpu_rst,
  input  logic raw_int,
  input  logic int_cfg,
  input  logic ack_clr,
  output logic pending
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  logic                   sync_out;
  logic                   rise;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~sync_prev_q;

  // Level mode mirrors the synchronised line and ignores acknowledges.
  // Edge mode: a new rise beats a simultaneous clear so no edge is lost.
  always_ff @(posedge wic_clk) begin
    if (pad_cpu_rst) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
      pending     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], raw_int};
      sync_prev_q <= sync_out;
      if (int_cfg == WIC_CFG_LEVEL) begin
        pending <= sync_out;
      end else if (rise) begin
        pending <= 1'b1;
      end else if (ack_clr) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/wic_ctrl.sv
// wic_ctrl: wake-up interrupt controller.
//   Collects INT_NUM interrupt sources into a pending vector for the VIC and,
//   while the core is asleep, raises a 4-phase wake request to the PMU naming
//   the lowest-index enabled pending source.
// Ports:
//   wic_clk              in   sole clock
//   pad_cpu_rst          in   synchronous active-high reset
//   pad_wic_int_vld      in   raw asynchronous interrupt lines
//   ctl_xx_int_cfg       in   per-source mode (0 level, 1 rising edge)
//   ctl_xx_awake_enable  in   per-source wake enable
//   cpu_wic_ack_vld      in   interrupt acknowledge strobe (1+ cycles)
//   cpu_wic_ack_id       in   acknowledged source index
//   ctl_xx_sleep_req     in   core entering / in low-power state
//   pmu_wic_wake_ack     in   PMU wake acknowledge
//   pad_vic_int_vld      out  pending vector
//   intraw_vld           out  any pending source with wake enabled
//   wic_pmu_wake_req     out  wake request to PMU
//   wic_wake_src_id      out  captured wake source index
//   wic_wake_src_vld     out  wic_wake_src_id valid
module wic_ctrl
  import wic_pkg::*;
#(
  parameter int INT_NUM     = 32,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = wic_id_width(INT_NUM)
) (
  input  logic               wic_clk,
  input  logic               pad_cpu_rst,
  input  logic [INT_NUM-1:0] pad_wic_int_vld,
  input  logic [INT_NUM-1:0] ctl_xx_int_cfg,
  input  logic [INT_NUM-1:0] ctl_xx_awake_enable,
  input  logic               cpu_wic_ack_vld,
  input  logic [ID_W-1:0]    cpu_wic_ack_id,
  input  logic               ctl_xx_sleep_req,
  input  logic               pmu_wic_wake_ack,
  output logic [INT_NUM-1:0] pad_vic_int_vld,
  output logic               intraw_vld,
  output logic               wic_pmu_wake_req,
  output logic [ID_W-1:0]    wic_wake_src_id,
  output logic               wic_wake_src_vld
);

  logic [INT_NUM-1:0] pending;
  logic [INT_NUM-1:0] ack_clr;
  logic [INT_NUM-1:0] wake_vec;
  logic [ID_W-1:0]    lowest_id;
  logic               ack_vld_q;
  logic               ack_pulse;
  wic_state_e         state;

  // Only the first cycle of a held acknowledge clears anything.
  assign ack_pulse = cpu_wic_ack_vld & ~ack_vld_q;

  always_ff @(posedge wic_clk) begin
    if (pad_cpu_rst) begin
      ack_vld_q <= 1'b0;
    end else begin
      ack_vld_q <= cpu_wic_ack_vld;
    end
  end

  // IDs at or above INT_NUM match no source and are dropped here.
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < INT_NUM; i++) begin
      ack_clr[i] = ack_pulse && (int'(cpu_wic_ack_id) == i);
    end
  end

  for (genvar g = 0; g < INT_NUM; g++) begin : g_src
    wic_int_src #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_src (
      .wic_clk    (wic_clk),
      .pad_cpu_rst(pad_cpu_rst),
      .raw_int    (pad_wic_int_vld[g]),
      .int_cfg    (ctl_xx_int_cfg[g]),
      .ack_clr    (ack_clr[g]),
      .pending    (pending[g])
    );
  end

  assign pad_vic_int_vld = pending;

  // Downward scan so the lowest set index is the last one written.
  always_comb begin
    wake_vec  = pending & ctl_xx_awake_enable;
    lowest_id = '0;
    for (int i = INT_NUM - 1; i >= 0; i--) begin
      if (wake_vec[i]) begin
        lowest_id = ID_W'(i);
      end
    end
  end

  assign intraw_vld = |wake_vec;

  // Wake handshake. The request and source outputs are registered alongside
  // the state so the PMU never sees a decode glitch.
  always_ff @(posedge wic_clk) begin
    if (pad_cpu_rst) begin
      state            <= IDLE;
      wic_pmu_wake_req <= 1'b0;
      wic_wake_src_id  <= '0;
      wic_wake_src_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ctl_xx_sleep_req) begin
            state <= ARMED;
          end
        end
        ARMED: begin
          if (!ctl_xx_sleep_req) begin
            state <= IDLE;
          end else if (intraw_vld) begin
            state            <= REQ;
            wic_pmu_wake_req <= 1'b1;
            wic_wake_src_id  <= lowest_id;
            wic_wake_src_vld <= 1'b1;
          end
        end
        REQ: begin
          if (pmu_wic_wake_ack) begin
            state            <= DROP;
            wic_pmu_wake_req <= 1'b0;
          end
        end
        DROP: begin
          if (!pmu_wic_wake_ack) begin
            state            <= IDLE;
            wic_wake_src_vld <= 1'b0;
          end
        end
        default: begin
          state            <= IDLE;
          wic_pmu_wake_req <= 1'b0;
          wic_wake_src_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule
